// File: rtl/nios_simple_lcd_i2c_pkg.sv
// nios_simple_lcd_i2c: shared register map, command bits and FSM encoding
// for the LCD control-bus I2C byte engine.
package nios_simple_lcd_i2c_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CMD    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CLKDIV = 2'd3;

   localparam int CMD_START   = 0;
   localparam int CMD_STOP    = 1;
   localparam int CMD_READ    = 2;
   localparam int CMD_WRITE   = 3;
   localparam int CMD_ACK_OUT = 4;

   localparam logic [15:0] DEFAULT_DIV = 16'd124;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP
   } state_e;

endpackage

// File: rtl/nios_simple_lcd_i2c_bit_timer.sv
// nios_simple_lcd_i2c: quarter-bit timer; a released-but-low SCL holds
// the quarter at its terminal count until the slave lets go.
module nios_simple_lcd_i2c_bit_timer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        freeze,
   input  logic [15:0] div,
   output logic        tick
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == div) begin
         if (!freeze) begin
            tick  = 1'b1;
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/nios_simple_lcd_i2c_master.sv
// nios_simple_lcd_i2c_master: Avalon-MM I2C byte engine driving open-drain
// SDA/SCL; one START/byte/STOP command per write, firmware polls busy.
module nios_simple_lcd_i2c_master #(
   parameter logic [15:0] DEFAULT_DIV = nios_simple_lcd_i2c_pkg::DEFAULT_DIV
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   inout  wire         sda,
   inout  wire         scl
);

   import nios_simple_lcd_i2c_pkg::*;

   state_e      state_q, state_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [2:0]  bit_q, bit_d;
   logic [4:0]  cmd_q, cmd_d, cmd_n;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  txl_q, txl_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  rsh_q, rsh_d;
   logic [15:0] div_q, div_d;
   logic        busy_q, busy_d;
   logic        nack_q, nack_d;
   logic        samp_q, samp_d;
   logic        sda_lo_q, sda_lo_d;
   logic        scl_lo_q, scl_lo_d;
   logic [1:0]  sda_sy_q, sda_sy_d;
   logic [1:0]  scl_sy_q, scl_sy_d;
   logic [31:0] rd_q, rd_d;
   logic        wr_en, accept, tick, freeze;
   logic        is_wr, is_rd, unused_wd;

   assign sda      = sda_lo_q ? 1'b0 : 1'bz;
   assign scl      = scl_lo_q ? 1'b0 : 1'bz;
   assign readdata = rd_q;

   assign wr_en  = chipselect & ~write_n;
   assign accept = wr_en && address == ADDR_CMD && !busy_q
                   && |writedata[3:0];
   assign cmd_n  = accept ? writedata[4:0] : cmd_q;
   assign is_wr  = cmd_n[CMD_WRITE];
   assign is_rd  = cmd_n[CMD_READ] & ~cmd_n[CMD_WRITE];
   assign freeze = ~scl_lo_q & ~scl_sy_q[1];

   assign unused_wd = ^writedata[31:16];

   nios_simple_lcd_i2c_bit_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state_q != ST_IDLE),
      .freeze  (freeze),
      .div     (div_q),
      .tick    (tick)
   );

   always_comb begin
      state_d  = state_q;
      qtr_d    = qtr_q;
      bit_d    = bit_q;
      busy_d   = busy_q;
      nack_d   = nack_q;
      cmd_d    = cmd_n;
      tx_d     = tx_q;
      txl_d    = txl_q;
      rx_d     = rx_q;
      rsh_d    = rsh_q;
      div_d    = div_q;
      sda_sy_d = {sda_sy_q[0], sda};
      scl_sy_d = {scl_sy_q[0], scl};
      samp_d   = tick && qtr_q == 2'd2
                 && (state_q == ST_BIT || state_q == ST_ACK);

      if (wr_en && address == ADDR_DATA)
         tx_d = writedata[7:0];
      if (wr_en && address == ADDR_CLKDIV && !busy_q)
         div_d = writedata[15:0];

      // samp_q marks the first cycle of Q3 while SCL is high
      if (samp_q) begin
         if (state_q == ST_BIT)
            rsh_d = {rsh_q[6:0], sda_sy_q[1]};
         else if (state_q == ST_ACK && is_wr)
            nack_d = sda_sy_q[1];
      end

      if (state_q == ST_IDLE) begin
         if (accept) begin
            busy_d = 1'b1;
            nack_d = 1'b0;
            txl_d  = tx_q;
            qtr_d  = 2'd0;
            bit_d  = 3'd7;
            if (cmd_n[CMD_START])
               state_d = ST_START;
            else if (is_wr || is_rd)
               state_d = ST_BIT;
            else
               state_d = ST_STOP;
         end
      end else if (tick) begin
         qtr_d = qtr_q + 2'd1;
         if (qtr_q == 2'd3) begin
            case (state_q)
               ST_START: begin
                  bit_d = 3'd7;
                  if (is_wr || is_rd) begin
                     state_d = ST_BIT;
                  end else if (cmd_q[CMD_STOP]) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                  end
               end
               ST_BIT: begin
                  if (bit_q == 3'd0) state_d = ST_ACK;
                  else               bit_d   = bit_q - 3'd1;
               end
               ST_ACK: begin
                  rx_d = rsh_q;
                  if (cmd_q[CMD_STOP]) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            endcase
         end
      end
   end

   // Pin drive follows the state being entered, so it is registered
   // in lockstep with the FSM.
   always_comb begin
      sda_lo_d = sda_lo_q;
      scl_lo_d = scl_lo_q;
      case (state_d)
         ST_START: begin
            sda_lo_d = qtr_d[1];
            if (qtr_d != 2'd0) scl_lo_d = 1'b0;
         end
         ST_BIT: begin
            sda_lo_d = is_wr & ~txl_d[bit_d];
            scl_lo_d = ~qtr_d[1];
         end
         ST_ACK: begin
            sda_lo_d = is_rd & ~cmd_n[CMD_ACK_OUT];
            scl_lo_d = ~qtr_d[1];
         end
         ST_STOP: begin
            sda_lo_d = qtr_d != 2'd3;
            scl_lo_d = qtr_d == 2'd0;
         end
         default: begin
            if (state_q == ST_STOP) begin
               sda_lo_d = 1'b0;
               scl_lo_d = 1'b0;
            end else if (state_q != ST_IDLE) begin
               sda_lo_d = state_q == ST_START;
               scl_lo_d = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_DATA:   rd_d = {24'd0, rx_q};
         ADDR_CMD:    rd_d = {27'd0, cmd_q};
         ADDR_STATUS: rd_d = {30'd0, nack_q, busy_q};
         default:     rd_d = {16'd0, div_q};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         qtr_q    <= '0;
         bit_q    <= '0;
         busy_q   <= 1'b0;
         nack_q   <= 1'b0;
         cmd_q    <= '0;
         tx_q     <= '0;
         txl_q    <= '0;
         rx_q     <= '0;
         rsh_q    <= '0;
         div_q    <= DEFAULT_DIV;
         samp_q   <= 1'b0;
         sda_lo_q <= 1'b0;
         scl_lo_q <= 1'b0;
         sda_sy_q <= 2'b11;
         scl_sy_q <= 2'b11;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         busy_q   <= busy_d;
         nack_q   <= nack_d;
         cmd_q    <= cmd_d;
         tx_q     <= tx_d;
         txl_q    <= txl_d;
         rx_q     <= rx_d;
         rsh_q    <= rsh_d;
         div_q    <= div_d;
         samp_q   <= samp_d;
         sda_lo_q <= sda_lo_d;
         scl_lo_q <= scl_lo_d;
         sda_sy_q <= sda_sy_d;
         scl_sy_q <= scl_sy_d;
         rd_q     <= rd_d;
      end
   end

endmodule

// File: tb/tb_nios_simple_lcd_i2c_master.sv
// tb_nios_simple_lcd_i2c_master: directed bench with a simple I2C slave
// model (ACK/NACK, read data, clock stretch) on pulled-up wires.
module tb_nios_simple_lcd_i2c_master;

   logic        clk;
   logic        rst_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   wire         sda_w;
   wire         scl_w;

   int n_cmp = 0;
   int n_bad = 0;

   logic       rd_mode, ack_en, stretch_en;
   logic [7:0] rd_byte;

   logic       s_sda_lo, s_scl_lo, scl_p, sda_p, ack_bit;
   logic [7:0] cap;
   int         r, hold, stops;

   pullup (sda_w);
   pullup (scl_w);
   assign sda_w = s_sda_lo ? 1'b0 : 1'bz;
   assign scl_w = s_scl_lo ? 1'b0 : 1'bz;

   nios_simple_lcd_i2c_master dut (
      .clk        (clk),
      .reset_n    (rst_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .sda        (sda_w),
      .scl        (scl_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave model, evaluated away from the DUT clock edge
   always @(negedge clk) begin
      if (!rst_n) begin
         r <= 0; hold <= 0;
         s_sda_lo <= 1'b0; s_scl_lo <= 1'b0;
         scl_p <= 1'b1; sda_p <= 1'b1;
      end else begin
         scl_p <= scl_w;
         sda_p <= sda_w;
         if (s_scl_lo) begin
            if (hold != 0) hold <= hold - 1;
            else           s_scl_lo <= 1'b0;
         end
         if (scl_p && scl_w && sda_p && !sda_w) begin
            r <= 0;
         end else if (scl_p && scl_w && !sda_p && sda_w) begin
            r <= 0;
            stops <= stops + 1;
         end else if (!scl_p && scl_w) begin
            if (r < 8)       cap <= {cap[6:0], sda_w};
            else if (r == 8) ack_bit <= sda_w;
            r <= r + 1;
         end else if (scl_p && !scl_w) begin
            if (rd_mode) s_sda_lo <= (r < 8) ? !rd_byte[3'(7 - r)] : 1'b0;
            else         s_sda_lo <= (r == 8) && ack_en;
            if (stretch_en && r == 3) begin
               s_scl_lo <= 1'b1;
               hold <= 48;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic cmd_measure(input logic [4:0] c, output int n,
                              output logic [31:0] st);
      avm_write(2'd1, {27'd0, c});
      address = 2'd2;
      n = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (readdata[0]) n++;
         else break;
      end
      st = readdata;
   endtask

   task automatic wait_idle();
      logic [31:0] v;
      v = 32'h1;
      for (int i = 0; i < 2000 && v[0]; i++) avm_read(2'd2, v);
      chk("wait_idle", {31'd0, v[0]}, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      int n, s0;
      rst_n = 1'b0; address = 2'd0; chipselect = 1'b0;
      write_n = 1'b1; writedata = '0;
      rd_mode = 1'b0; ack_en = 1'b1; stretch_en = 1'b0; rd_byte = 8'h00;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;

      avm_read(2'd0, v); chk("rst_data", v, 32'h0);
      avm_read(2'd1, v); chk("rst_cmd", v, 32'h0);
      avm_read(2'd2, v); chk("rst_status", v, 32'h0);
      avm_read(2'd3, v); chk("rst_div", v, 32'h7C);
      chk("rst_sda", {31'd0, sda_w}, 32'd1);
      chk("rst_scl", {31'd0, scl_w}, 32'd1);

      avm_write(2'd3, 32'd4);
      avm_read(2'd3, v); chk("div_wr", v, 32'd4);

      // START+WRITE 0xA5, slave ACKs
      avm_write(2'd0, 32'hA5);
      cmd_measure(5'h09, n, v);
      chk("wr_busy", n, 200);
      chk("wr_status", v, 32'h0);
      chk("wr_bits", {24'd0, cap}, 32'hA5);
      chk("wr_ack", {31'd0, ack_bit}, 32'd0);
      avm_read(2'd0, v); chk("wr_rx", v, 32'hA5);

      // repeated START+WRITE, slave NACKs
      ack_en = 1'b0;
      cmd_measure(5'h09, n, v);
      chk("nk_busy", n, 200);
      chk("nk_status", v, 32'h2);
      chk("nk_bits", {24'd0, cap}, 32'hA5);

      // STOP only
      s0 = stops;
      cmd_measure(5'h02, n, v);
      chk("stop_busy", n, 20);
      chk("stop_seen", stops, s0 + 1);
      chk("stop_sda", {31'd0, sda_w}, 32'd1);
      chk("stop_scl", {31'd0, scl_w}, 32'd1);

      // READ+STOP with NACK, slave sends 0x3C
      rd_mode = 1'b1; rd_byte = 8'h3C;
      s0 = stops;
      cmd_measure(5'h16, n, v);
      chk("rd_busy", n, 200);
      chk("rd_status", v, 32'h0);
      chk("rd_ackslot", {31'd0, ack_bit}, 32'd1);
      chk("rd_stop", stops, s0 + 1);
      avm_read(2'd0, v); chk("rd_data", v, 32'h3C);
      chk("rd_bus", {30'd0, sda_w, scl_w}, 32'h3);

      // 37-cycle clock stretch during bit 3
      rd_mode = 1'b0; ack_en = 1'b1; stretch_en = 1'b1;
      avm_write(2'd0, 32'h5A);
      cmd_measure(5'h09, n, v);
      stretch_en = 1'b0;
      chk("st_busy", n, 237);
      chk("st_status", v, 32'h0);
      chk("st_bits", {24'd0, cap}, 32'h5A);

      // CMD and CLKDIV writes while busy are dropped
      avm_write(2'd0, 32'h81);
      avm_write(2'd1, 32'h09);
      repeat (10) @(negedge clk);
      avm_write(2'd1, 32'h02);
      avm_write(2'd3, 32'h9);
      wait_idle();
      avm_read(2'd1, v); chk("bz_cmd", v, 32'h09);
      avm_read(2'd3, v); chk("bz_div", v, 32'd4);
      chk("bz_bits", {24'd0, cap}, 32'h81);

      // asynchronous reset in bit 1, Q1, while both lines are driven low
      avm_write(2'd0, 32'h00);
      avm_write(2'd1, 32'h09);
      repeat (47) @(negedge clk);
      chk("mid_low", {30'd0, sda_w, scl_w}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_sda_z", {31'd0, sda_w}, 32'd1);
      chk("rst_scl_z", {31'd0, scl_w}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      avm_read(2'd2, v); chk("post_status", v, 32'h0);
      avm_read(2'd3, v); chk("post_div", v, 32'h7C);
      avm_read(2'd1, v); chk("post_cmd", v, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
